// File: rtl/cnn_layer_accel_net_ctrl.sv
// rtl/cnn_layer_accel_net_ctrl.sv - network command controller: seq load, layer config, row-by-row input fetch
module cnn_layer_accel_net_ctrl #(
  parameter int C_PAYLOAD_WIDTH = 128,
  parameter int C_SEQ_LINE_AW   = 9,
  parameter int C_CFG_WIDTH     = 16
) (
  input  logic                       network_clk,
  input  logic                       network_rst,
  input  logic                       from_network_valid,
  output logic                       from_network_accept,
  input  logic [C_PAYLOAD_WIDTH-1:0] from_network_payload,
  output logic                       to_network_valid,
  input  logic                       to_network_accept,
  output logic [C_PAYLOAD_WIDTH-1:0] to_network_payload,
  output logic                       seq_wren,
  output logic [C_SEQ_LINE_AW-1:0]   seq_wr_addr,
  output logic [C_PAYLOAD_WIDTH-1:0] seq_wr_data,
  output logic [C_CFG_WIDTH-1:0]     num_input_rows_cfg,
  output logic [C_CFG_WIDTH-1:0]     num_input_cols_cfg,
  output logic [C_CFG_WIDTH-1:0]     num_input_depth_cfg,
  output logic                       start,
  output logic                       pix_valid,
  input  logic                       pix_accept,
  output logic [C_PAYLOAD_WIDTH-1:0] pix_data,
  output logic                       busy,
  output logic                       done,
  output logic                       err_opcode
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SEQ_LOAD = 3'd1;
  localparam logic [2:0] S_START    = 3'd2;
  localparam logic [2:0] S_ROW_REQ  = 3'd3;
  localparam logic [2:0] S_ROW_DATA = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  localparam logic [3:0] OP_CFG      = 4'h1;
  localparam logic [3:0] OP_SEQ_LOAD = 4'h2;
  localparam logic [3:0] OP_START    = 4'h3;
  localparam logic [3:0] OP_ROW_REQ  = 4'h4;

  logic [2:0]               state;
  logic [C_SEQ_LINE_AW-1:0] seq_len;
  logic [C_SEQ_LINE_AW-1:0] seq_cnt;
  logic [C_CFG_WIDTH-1:0]   row_cnt;
  logic [C_CFG_WIDTH-1:0]   col_cnt;
  logic [3:0]               opcode;
  logic                     pix_xfer;

  assign opcode   = from_network_payload[C_PAYLOAD_WIDTH-1 -: 4];
  assign pix_xfer = (state == S_ROW_DATA) && from_network_valid && pix_accept;

  always_ff @(posedge network_clk or posedge network_rst) begin
    if (network_rst) begin
      state               <= S_IDLE;
      seq_len             <= '0;
      seq_cnt             <= '0;
      row_cnt             <= '0;
      col_cnt             <= '0;
      seq_wren            <= 1'b0;
      seq_wr_addr         <= '0;
      seq_wr_data         <= '0;
      num_input_rows_cfg  <= '0;
      num_input_cols_cfg  <= '0;
      num_input_depth_cfg <= '0;
      err_opcode          <= 1'b0;
    end else begin
      seq_wren   <= 1'b0;
      err_opcode <= 1'b0;
      case (state)
        S_IDLE: begin
          if (from_network_valid) begin
            case (opcode)
              OP_CFG: begin
                num_input_rows_cfg  <= from_network_payload[47:32];
                num_input_cols_cfg  <= from_network_payload[31:16];
                num_input_depth_cfg <= from_network_payload[15:0];
              end
              OP_SEQ_LOAD: begin
                seq_len <= from_network_payload[C_SEQ_LINE_AW-1:0];
                seq_cnt <= '0;
                state   <= S_SEQ_LOAD;
              end
              OP_START: state <= S_START;
              default:  err_opcode <= 1'b1;
            endcase
          end
        end
        S_SEQ_LOAD: begin
          if (from_network_valid) begin
            seq_wren    <= 1'b1;
            seq_wr_addr <= seq_cnt;
            seq_wr_data <= from_network_payload;
            seq_cnt     <= seq_cnt + 1'b1;
            // The terminal beat exits before the counter wrap can matter.
            if (seq_cnt == seq_len) state <= S_IDLE;
          end
        end
        S_START: begin
          row_cnt <= '0;
          state   <= S_ROW_REQ;
        end
        S_ROW_REQ: begin
          if (to_network_accept) begin
            col_cnt <= '0;
            state   <= S_ROW_DATA;
          end
        end
        S_ROW_DATA: begin
          if (pix_xfer) begin
            col_cnt <= col_cnt + 1'b1;
            if (col_cnt == num_input_cols_cfg) begin
              if (row_cnt == num_input_rows_cfg) begin
                state <= S_DONE;
              end else begin
                row_cnt <= row_cnt + 1'b1;
                state   <= S_ROW_REQ;
              end
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    from_network_accept = 1'b0;
    case (state)
      S_IDLE, S_SEQ_LOAD: from_network_accept = 1'b1;
      S_ROW_DATA:         from_network_accept = pix_accept;
      default:            from_network_accept = 1'b0;
    endcase
  end

  // Row data bypasses any register so the quad sees network beats with zero latency.
  assign pix_valid = (state == S_ROW_DATA) && from_network_valid;
  assign pix_data  = (state == S_ROW_DATA) ? from_network_payload : '0;

  assign to_network_valid   = (state == S_ROW_REQ);
  assign to_network_payload = (state == S_ROW_REQ)
                            ? {OP_ROW_REQ, {(C_PAYLOAD_WIDTH-4-C_CFG_WIDTH){1'b0}}, row_cnt}
                            : '0;

  assign start = (state == S_START);
  assign done  = (state == S_DONE);
  assign busy  = (state != S_IDLE);

endmodule

// File: tb/tb_cnn_layer_accel_net_ctrl.sv
// tb/tb_cnn_layer_accel_net_ctrl.sv - randomized self-checking bench for cnn_layer_accel_net_ctrl
module tb_cnn_layer_accel_net_ctrl;

  logic         network_clk = 1'b0;
  logic         network_rst;
  logic         from_network_valid;
  logic         from_network_accept;
  logic [127:0] from_network_payload;
  logic         to_network_valid;
  logic         to_network_accept;
  logic [127:0] to_network_payload;
  logic         seq_wren;
  logic [8:0]   seq_wr_addr;
  logic [127:0] seq_wr_data;
  logic [15:0]  num_input_rows_cfg;
  logic [15:0]  num_input_cols_cfg;
  logic [15:0]  num_input_depth_cfg;
  logic         start;
  logic         pix_valid;
  logic         pix_accept;
  logic [127:0] pix_data;
  logic         busy;
  logic         done;
  logic         err_opcode;

  always #5 network_clk = ~network_clk;

  cnn_layer_accel_net_ctrl dut (
    .network_clk          (network_clk),
    .network_rst          (network_rst),
    .from_network_valid   (from_network_valid),
    .from_network_accept  (from_network_accept),
    .from_network_payload (from_network_payload),
    .to_network_valid     (to_network_valid),
    .to_network_accept    (to_network_accept),
    .to_network_payload   (to_network_payload),
    .seq_wren             (seq_wren),
    .seq_wr_addr          (seq_wr_addr),
    .seq_wr_data          (seq_wr_data),
    .num_input_rows_cfg   (num_input_rows_cfg),
    .num_input_cols_cfg   (num_input_cols_cfg),
    .num_input_depth_cfg  (num_input_depth_cfg),
    .start                (start),
    .pix_valid            (pix_valid),
    .pix_accept           (pix_accept),
    .pix_data             (pix_data),
    .busy                 (busy),
    .done                 (done),
    .err_opcode           (err_opcode)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [136:0] obs, input logic [136:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [136:0] seq_obs[$];
  logic [136:0] seq_exp[$];
  logic [127:0] pix_obs[$];
  logic [127:0] pix_exp[$];
  int           req_obs[$];
  int           n_start = 0, n_done = 0, n_errop = 0;
  int           cyc = 0, last_pix_cyc = 0, done_cyc = 0;
  int           req_delay = 0, wait_cnt = 0, pix_mode = 0;
  logic         req_pending = 1'b0;
  logic [127:0] req_prev = '0;
  logic [111:0] req_hdr_exp = {4'h4, 108'd0};

  always @(posedge network_clk) cyc++;

  // Observers: everything sampled on the falling edge, where inputs are already settled.
  always @(negedge network_clk) begin
    if (!network_rst) begin
      if (seq_wren) seq_obs.push_back({seq_wr_addr, seq_wr_data});
      if (start) n_start++;
      if (done) begin n_done++; done_cyc = cyc; end
      if (err_opcode) n_errop++;
      if (pix_valid) begin
        chk("accept_mirror", from_network_accept, pix_accept);
        if (pix_accept) begin pix_obs.push_back(pix_data); last_pix_cyc = cyc; end
      end
      if (to_network_valid) begin
        chk("req_header", to_network_payload[127:16], req_hdr_exp);
        if (req_pending) chk("req_hold", to_network_payload, req_prev);
        if (to_network_accept) req_obs.push_back(int'(to_network_payload[15:0]));
      end
      req_pending = to_network_valid && !to_network_accept;
      req_prev    = to_network_payload;
    end
  end

  always @(posedge network_clk) begin
    #1;
    if (to_network_valid) begin
      if (wait_cnt >= req_delay) to_network_accept = 1'b1;
      else wait_cnt++;
    end else begin
      to_network_accept = 1'b0;
      wait_cnt = 0;
    end
    case (pix_mode)
      0:       pix_accept = 1'b1;
      1:       pix_accept = ~pix_accept;
      default: pix_accept = 1'($urandom_range(0, 1));
    endcase
  end

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] cmd(input logic [3:0] op, input logic [47:0] lo);
    return {op, 76'd0, lo};
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge network_clk); #1; end
  endtask

  task automatic send(input logic [127:0] p);
    logic acc;
    acc = 1'b0;
    from_network_valid   = 1'b1;
    from_network_payload = p;
    for (int n = 0; n < 300 && !acc; n++) begin
      @(negedge network_clk);
      acc = from_network_accept;
      @(posedge network_clk);
      #1;
    end
    if (!acc) chk("send_timeout", 0, 1);
    from_network_valid = 1'b0;
  endtask

  task automatic send_cfg(input int r, input int c, input int d);
    send(cmd(4'h1, {16'(r), 16'(c), 16'(d)}));
    chk("cfg_rows", num_input_rows_cfg, 16'(r));
    chk("cfg_cols", num_input_cols_cfg, 16'(c));
    chk("cfg_depth", num_input_depth_cfg, 16'(d));
  endtask

  task automatic check_seq();
    int n;
    chk("seq_count", seq_obs.size(), seq_exp.size());
    n = (seq_obs.size() < seq_exp.size()) ? seq_obs.size() : seq_exp.size();
    for (int i = 0; i < n; i++) chk("seq_line", seq_obs[i], seq_exp[i]);
  endtask

  task automatic do_seq(input int len);
    logic [127:0] d;
    seq_obs.delete();
    seq_exp.delete();
    send(cmd(4'h2, 48'(len)));
    for (int i = 0; i <= len; i++) begin
      if (len > 100 && i == len / 2) idle(3);
      else if ($urandom_range(0, 9) == 0) idle($urandom_range(1, 2));
      d = rnd128();
      seq_exp.push_back({9'(i), d});
      send(d);
    end
    idle(2);
    check_seq();
    chk("seq_idle", busy, 0);
  endtask

  task automatic do_run(input int rows, input int cols, input int rdelay, input int pmode);
    int s0, d0;
    logic [127:0] d;
    send_cfg(rows, cols, $urandom_range(0, 15));
    pix_obs.delete();
    pix_exp.delete();
    req_obs.delete();
    s0 = n_start;
    d0 = n_done;
    req_delay = rdelay;
    pix_mode  = pmode;
    send(cmd(4'h3, 0));
    for (int i = 0; i < (rows + 1) * (cols + 1); i++) begin
      d = rnd128();
      pix_exp.push_back(d);
      send(d);
    end
    // Next command arrives while the controller is still finishing; it must wait, then apply.
    send_cfg(rows + 5, cols + 3, 2);
    chk("start_pulses", n_start - s0, 1);
    chk("done_pulses", n_done - d0, 1);
    chk("done_timing", done_cyc, last_pix_cyc + 1);
    chk("req_count", req_obs.size(), rows + 1);
    for (int r = 0; r < req_obs.size() && r <= rows; r++) chk("req_row", req_obs[r], r);
    chk("pix_count", pix_obs.size(), pix_exp.size());
    for (int i = 0; i < pix_obs.size() && i < pix_exp.size(); i++) chk("pix_beat", pix_obs[i], pix_exp[i]);
    pix_mode = 0;
  endtask

  initial begin
    int e0;
    network_rst          = 1'b1;
    from_network_valid   = 1'b0;
    from_network_payload = '0;
    to_network_accept    = 1'b0;
    pix_accept           = 1'b0;
    repeat (2) @(posedge network_clk);
    @(negedge network_clk);
    chk("rst_busy", busy, 0);
    chk("rst_seq_wren", seq_wren, 0);
    chk("rst_start", start, 0);
    chk("rst_done", done, 0);
    chk("rst_req_valid", to_network_valid, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_cfg", {num_input_rows_cfg, num_input_cols_cfg, num_input_depth_cfg}, 0);
    @(posedge network_clk);
    #1 network_rst = 1'b0;
    idle(1);

    send_cfg(9, 9, 7);
    idle(1);
    chk("cfg_no_busy", busy, 0);
    chk("cfg_no_start", n_start, 0);

    e0 = n_errop;
    send(cmd(4'hF, 48'h123));
    chk("err_busy", busy, 0);
    idle(2);
    chk("err_pulses", n_errop - e0, 1);

    do_seq(511);
    do_seq(0);
    send_cfg(3, 4, 5);

    do_run(1, 2, 2, 0);
    do_run(2, 1, 0, 1);
    for (int k = 0; k < 4; k++)
      do_run($urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3), 2);
    for (int k = 0; k < 3; k++) do_seq($urandom_range(1, 20));

    // Abort a long load part-way with reset, then confirm the next load starts over.
    seq_obs.delete();
    send(cmd(4'h2, 48'd511));
    for (int i = 0; i < 100; i++) send(rnd128());
    network_rst = 1'b1;
    #1;
    chk("abort_wren", seq_wren, 0);
    chk("abort_busy", busy, 0);
    chk("abort_addr", seq_wr_addr, 0);
    chk("abort_cfg", {num_input_rows_cfg, num_input_cols_cfg, num_input_depth_cfg}, 0);
    chk("abort_seen", seq_obs.size(), 99);
    @(posedge network_clk);
    #1 network_rst = 1'b0;
    idle(1);
    do_seq(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cnn_layer_accel_net_ctrl.md
Name: cnn_layer_accel_net_ctrl

Overview:
Network-side command controller for the AWP accelerator. It decodes 128-bit command beats from the network interface and sequences the accelerator through three jobs: loading sequencer memory lines, writing the quad layer configuration (rows/cols/depth), and, after a start command, fetching the input map row by row. It sits between the network interface and the quad, and replaces direct register and memory pokes with a proper handshake-driven load/config/start flow.

Parameters:
C_PAYLOAD_WIDTH, 128, network beat width; also the sequencer line width (8 x 16-bit entries).
C_SEQ_LINE_AW, 9, sequencer line address width (512 lines).
C_CFG_WIDTH, 16, width of each rows/cols/depth config field.

Ports:
network_clk  in  1  clock
network_rst  in  1  reset, asynchronous, active-high
from_network_valid  in  1  command/data beat valid
from_network_accept  out  1  beat accepted
from_network_payload  in  C_PAYLOAD_WIDTH  command/data beat
to_network_valid  out  1  row request valid
to_network_accept  in  1  row request accepted
to_network_payload  out  C_PAYLOAD_WIDTH  row request: [127:124]=4'h4, [15:0]=row index, all other bits 0
seq_wren  out  1  sequencer line write strobe
seq_wr_addr  out  C_SEQ_LINE_AW  sequencer line address
seq_wr_data  out  C_PAYLOAD_WIDTH  sequencer line data
num_input_rows_cfg  out  C_CFG_WIDTH  rows-1
num_input_cols_cfg  out  C_CFG_WIDTH  cols-1
num_input_depth_cfg  out  C_CFG_WIDTH  depth-1
start  out  1  one-cycle quad start pulse
pix_valid  out  1  input-map beat to quad valid
pix_accept  in  1  quad accepts beat
pix_data  out  C_PAYLOAD_WIDTH  input-map beat (8 depth lanes x 16 bits)
busy  out  1  state != IDLE
done  out  1  one-cycle pulse after the last row is forwarded
err_opcode  out  1  one-cycle pulse on an unknown opcode

Behaviour:
- Transfer occurs when valid && accept, on the rising edge of network_clk.
- Reset: state IDLE. All outputs 0, including the cfg registers, address counter and row/col counters. Reset asserted mid-operation aborts immediately; any partial seq load or row fetch is discarded.
- Opcode is payload[127:124]; it is decoded only in IDLE.
- States: IDLE, SEQ_LOAD, START, ROW_REQ, ROW_DATA, DONE.
- IDLE: from_network_accept=1. On an accepted beat:
  - 4'h1 CFG: rows<=[47:32], cols<=[31:16], depth<=[15:0]. Stay in IDLE. Cfg outputs update the cycle after acceptance.
  - 4'h2 SEQ_LOAD: len<=[8:0] (lines-1), addr counter<=0, go to SEQ_LOAD.
  - 4'h3 START: go to START.
  - Any other opcode: beat dropped, err_opcode pulses for one cycle, stay in IDLE.
- SEQ_LOAD: from_network_accept=1. Each accepted beat is registered onto seq_wren=1, seq_wr_addr=counter, seq_wr_data=payload, one cycle after acceptance. seq_wren is otherwise 0.
  - The counter increments per accepted beat. The beat with counter==len returns to IDLE.
  - len=0 loads exactly one line. len=511 writes addresses 0..511 with no wrap.
  - Gaps in valid simply stall the load.
- START: start=1 for exactly one cycle, row counter<=0, then ROW_REQ. from_network_accept=0.
- ROW_REQ: to_network_valid=1 with row index = row counter. Payload is held stable until accepted. On acceptance: col counter<=0, go to ROW_DATA.
- ROW_DATA: combinational pass-through, zero latency:
  - pix_valid = from_network_valid
  - pix_data = from_network_payload
  - from_network_accept = pix_accept
  - Per accepted beat the col counter increments. At the beat with col==num_input_cols_cfg:
    - if row==num_input_rows_cfg, go to DONE;
    - otherwise row+1 and go to ROW_REQ.
  - Opcodes are not decoded here; every beat is treated as data.
- DONE: done=1 for one cycle, then IDLE.
- Outside IDLE and SEQ_LOAD, from_network_accept follows the rules above and is 0 in START, ROW_REQ and DONE. Commands arriving while busy are backpressured, never dropped.
- Cfg registers are not modified by START/RUN. A CFG command is impossible while busy (backpressure).
- Config value 0 means one row or one column. Counters are C_CFG_WIDTH wide; comparison uses equality only.

Test Plan:
- CFG beat with rows=9, cols=9, depth=7 -> cfg outputs 9/9/7 the next cycle. No start, busy=0.
- SEQ_LOAD len=511 followed by 512 beats, with valid deasserted for 3 cycles mid-stream -> 512 seq_wren pulses, addresses 0..511 in order, data matches each beat delayed 1 cycle, back in IDLE.
- SEQ_LOAD len=0 plus one beat -> single write to address 0, then the following opcode is decoded normally.
- CFG rows=1, cols=2, then START, with to_network_accept delayed 2 cycles -> one start pulse, row requests 0 then 1 with payload held while waiting, 3 pix beats per row, done pulse after the 6th beat.
- During ROW_DATA, pix_accept toggling 1/0 -> from_network_accept mirrors it and no beat is lost or duplicated. A CFG beat sent while busy is stalled until IDLE, then applied.
- Opcode 4'hF in IDLE -> err_opcode pulse, no state change. Assert network_rst mid-SEQ_LOAD at beat 100 -> all outputs 0 immediately, and the next SEQ_LOAD restarts at address 0.
